hash_round_ctrl: RTL and testbench
==================================

# hash_round_ctrl

Sequencing controller for the hash generator's round datapath. It accepts a start request and pulls `NBLOCKS` message blocks through a valid/ready handshake. For each block it drives the 3-bit round counter's `init`/`en` and watches its carry-out, then presents the digest through a valid/ready handshake. It sits between the message source, the round-counter/round-logic datapath and the digest consumer.

## Interface
- `NBLOCKS`, 2: message blocks per hash; legal range 1..8.
- `BW`, `$clog2(NBLOCKS)`, minimum 1: block-counter width.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  hash request; sampled only in IDLE.
- `msg_valid`  in  1  message source holds a block.
- `msg_ready`  out  1  controller accepts a block; high only in LOAD.
- `msg_ld`  out  1  datapath loads the block this cycle; equals `msg_valid & msg_ready`.
- `blk_first`  out  1  high while processing block 0; datapath selects IV instead of chaining value.
- `cnt_init`  out  1  to round counter `init`.
- `cnt_en`  out  1  to round counter `en`.
- `rnd_co`  in  1  round counter carry-out; high when count == 5.
- `rnd_en`  out  1  round logic performs one round this cycle.
- `busy`  out  1  state != IDLE.
- `dig_valid`  out  1  digest available; held until accepted.
- `dig_ready`  in  1  consumer accepts the digest.

## Operation
- States: IDLE, LOAD, ROUND, OUT; 2-bit encoding. Internal block counter `blk` is `BW` bits.
- IDLE:
  - `cnt_init`=1 and `blk`=0.
  - `start`=1 -> LOAD.
- LOAD:
  - `msg_ready`=1 and `cnt_init`=1.
  - On `msg_valid`=1 the block transfers (`msg_ld`=1) -> ROUND. Otherwise stay in LOAD indefinitely.
- ROUND:
  - `rnd_en` = `cnt_en` = `~rnd_co`.
  - When `rnd_co`=1: `rnd_en`=0 and `cnt_en`=0.
    - If `blk` == NBLOCKS-1 -> OUT.
    - Otherwise `blk`+1 -> LOAD.
- OUT:
  - `dig_valid`=1.
  - `dig_ready`=1 -> IDLE and `blk` clears.
- `blk_first` = (`blk`==0) & (state is LOAD or ROUND).
- Exactly 5 `rnd_en` cycles per block: counter values 0..4, because the counter is initialised during LOAD.
- `rnd_co` is ignored outside ROUND.
- `start` is ignored outside IDLE; it is a level and is not queued.
- `dig_ready` is ignored outside OUT.
- `msg_valid` is ignored outside LOAD.
- `blk` never wraps; its terminal value is NBLOCKS-1.

## Timing
- Reset values: state=IDLE, `blk`=0, `cnt_init`=1. All other outputs are 0.
- Reset mid-operation: controller returns to IDLE asynchronously. Any partial block or digest is discarded and no `dig_valid` is produced.
- All outputs are combinational from state and the listed inputs; there are no registered outputs.
- Per block with `msg_valid` already high: 1 LOAD cycle + 6 ROUND cycles (5 rounds + 1 carry-out cycle).
- Start to `dig_valid`, NBLOCKS=1, `msg_valid` constant high: `start` sampled at edge 0 -> LOAD in cycle 1 -> ROUND in cycles 2..7 -> `dig_valid` from cycle 8.
- Each additional block adds 7 cycles.
- `dig_valid` with `dig_ready` high in the same cycle: digest is accepted and IDLE follows at the next edge. A new `start` is sampled one cycle later.

## Configuration
- Macro `HASH_ROUND_CTRL_ABORT_EN`.
- Defined: adds input `abort` (1 bit).
  - `abort`=1 in any non-IDLE state -> IDLE at the next edge and `blk` clears.
  - Abort has priority over every other transition, including `dig_ready` in OUT and `rnd_co` in ROUND.
  - `dig_valid` is not asserted after an abort.
- Undefined: the `abort` port does not exist and the state machine has no abort transitions.

## Test plan
- Single hash, NBLOCKS=1, `msg_valid` high: `start` pulse -> `msg_ld` in cycle 1; `rnd_en` high for exactly cycles 2..6; `dig_valid` in cycle 8; `dig_ready` -> `busy`=0 in the following cycle.
- NBLOCKS=2, `msg_valid` delayed 3 cycles for block 1: exactly 10 `rnd_en` pulses and 2 `msg_ld` pulses; `blk_first` high only during block 0; `dig_valid` held while `dig_ready`=0 for 4 cycles.
- Spurious inputs: `rnd_co` forced high in IDLE/LOAD, `start` pulsed during ROUND, `dig_ready` high in IDLE -> no state change and no extra `rnd_en`.
- Reset asserted mid-ROUND, block 1 (`blk`=1) -> `busy`=0 and `cnt_init`=1 immediately, without waiting for a clock edge; next hash produces `blk_first`=1 on its first block.
- Back-to-back: `start` held high through OUT acceptance -> second hash starts one cycle after returning to IDLE.
- With `HASH_ROUND_CTRL_ABORT_EN`: `abort` in cycle 4 -> IDLE at cycle 5; no `dig_valid`; subsequent hash completes normally.

Source files
------------

// File: rtl/hash_round_ctrl.sv
// Round-sequencing controller: pulls NBLOCKS message blocks, runs 5 rounds per block, presents digest.
// Optional HASH_ROUND_CTRL_ABORT_EN adds i_abort, which returns any active hash to IDLE.
module hash_round_ctrl #(
  parameter int NBLOCKS = 2,
  parameter int BW      = (NBLOCKS > 1) ? $clog2(NBLOCKS) : 1
) (
`ifdef HASH_ROUND_CTRL_ABORT_EN
  input  logic i_abort,
`endif
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_msg_valid,
  output logic o_msg_ready,
  output logic o_msg_ld,
  output logic o_blk_first,
  output logic o_cnt_init,
  output logic o_cnt_en,
  input  logic i_rnd_co,
  output logic o_rnd_en,
  output logic o_busy,
  output logic o_dig_valid,
  input  logic i_dig_ready
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROUND, S_OUT} state_t;

  localparam logic [BW-1:0] LAST = BW'(NBLOCKS - 1);

  state_t          r_state, w_state_nxt;
  logic [BW-1:0]   r_blk, w_blk_nxt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_blk   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_blk   <= w_blk_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_blk_nxt   = r_blk;
    o_msg_ready = 1'b0;
    o_cnt_init  = 1'b0;
    o_cnt_en    = 1'b0;
    o_rnd_en    = 1'b0;
    o_dig_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_cnt_init = 1'b1;
        w_blk_nxt  = '0;
        if (i_start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        // round counter is cleared here so the block gets counts 0..4
        o_msg_ready = 1'b1;
        o_cnt_init  = 1'b1;
        if (i_msg_valid) w_state_nxt = S_ROUND;
      end
      S_ROUND: begin
        o_rnd_en = ~i_rnd_co;
        o_cnt_en = ~i_rnd_co;
        if (i_rnd_co) begin
          if (r_blk == LAST) begin
            w_state_nxt = S_OUT;
          end else begin
            w_blk_nxt   = r_blk + 1'b1;
            w_state_nxt = S_LOAD;
          end
        end
      end
      S_OUT: begin
        o_dig_valid = 1'b1;
        if (i_dig_ready) begin
          w_state_nxt = S_IDLE;
          w_blk_nxt   = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
`ifdef HASH_ROUND_CTRL_ABORT_EN
    if (i_abort && r_state != S_IDLE) begin
      w_state_nxt = S_IDLE;
      w_blk_nxt   = '0;
    end
`endif
  end

  assign o_msg_ld    = i_msg_valid & o_msg_ready;
  assign o_busy      = (r_state != S_IDLE);
  assign o_blk_first = (r_blk == '0) && (r_state == S_LOAD || r_state == S_ROUND);

endmodule

// File: tb/tb_hash_round_ctrl.sv
// Directed bench: NBLOCKS=1 and NBLOCKS=2 controllers, each driving a 3-bit round counter model.
module tb_hash_round_ctrl;
  logic clk = 1'b0;
  logic rst, start, msg_valid, dig_ready, co_force, abort;
  always #5 clk = ~clk;

  logic rdy1, ld1, bf1, ci1, ce1, re1, busy1, dv1;
  logic rdy2, ld2, bf2, ci2, ce2, re2, busy2, dv2;
  logic [2:0] cnt1 = 3'd0, cnt2 = 3'd0;
  logic co1, co2;

  assign co1 = (cnt1 == 3'd5);
  assign co2 = (cnt2 == 3'd5) | co_force;

  always @(posedge clk) begin
    if (ci1) cnt1 <= 3'd0; else if (ce1) cnt1 <= cnt1 + 3'd1;
    if (ci2) cnt2 <= 3'd0; else if (ce2) cnt2 <= cnt2 + 3'd1;
  end

  hash_round_ctrl #(.NBLOCKS(1)) dut1 (
`ifdef HASH_ROUND_CTRL_ABORT_EN
    .i_abort(abort),
`endif
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_msg_valid(msg_valid),
    .o_msg_ready(rdy1), .o_msg_ld(ld1), .o_blk_first(bf1), .o_cnt_init(ci1),
    .o_cnt_en(ce1), .i_rnd_co(co1), .o_rnd_en(re1), .o_busy(busy1),
    .o_dig_valid(dv1), .i_dig_ready(dig_ready));

  hash_round_ctrl #(.NBLOCKS(2)) dut2 (
`ifdef HASH_ROUND_CTRL_ABORT_EN
    .i_abort(abort),
`endif
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_msg_valid(msg_valid),
    .o_msg_ready(rdy2), .o_msg_ld(ld2), .o_blk_first(bf2), .o_cnt_init(ci2),
    .o_cnt_en(ce2), .i_rnd_co(co2), .o_rnd_en(re2), .o_busy(busy2),
    .o_dig_valid(dv2), .i_dig_ready(dig_ready));

  int n_chk = 0, n_err = 0, cyc = 0;
  int n_rnd1, first_rnd1, last_rnd1, first_dv1;
  int n_rnd2, n_ld2, n_bf2, n_dv2, first_dv2;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clr();
    n_rnd1 = 0; first_rnd1 = -1; last_rnd1 = -1; first_dv1 = -1;
    n_rnd2 = 0; n_ld2 = 0; n_bf2 = 0; n_dv2 = 0; first_dv2 = -1;
  endtask

  // accumulate the current cycle at the falling edge, then advance one cycle
  task automatic nxt();
    @(negedge clk);
    if (re1) begin n_rnd1++; last_rnd1 = cyc; if (first_rnd1 < 0) first_rnd1 = cyc; end
    if (dv1 && first_dv1 < 0) first_dv1 = cyc;
    n_rnd2 += int'(re2); n_ld2 += int'(ld2); n_bf2 += int'(bf2); n_dv2 += int'(dv2);
    if (dv2 && first_dv2 < 0) first_dv2 = cyc;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_rst();
    rst = 1'b1; start = 1'b0; msg_valid = 1'b0; dig_ready = 1'b0;
    co_force = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // arm a hash: start sampled at the next edge (edge 0), which begins cycle 1
  task automatic go();
    start = 1'b1; cyc = 0; clr();
    nxt();
  endtask

  initial begin
    do_rst();
    #2;
    chk("rst_busy", int'(busy2), 0);
    chk("rst_cnt_init", int'(ci2), 1);
    chk("rst_dig_valid", int'(dv2), 0);
    chk("rst_rnd_en", int'(re2), 0);

    // single hash on both instances, msg_valid always high, digest held
    nxt(); msg_valid = 1'b1; go(); start = 1'b0;
    #3;
    chk("t1_ld1_c1", int'(ld1), 1);
    chk("t1_bf2_c1", int'(bf2), 1);
    while (cyc < 16) nxt();
    #3;
    chk("t1_dv1_held", int'(dv1), 1);
    chk("t1_dv2_c16", int'(dv2), 1);
    dig_ready = 1'b1;
    nxt(); #3;
    chk("t1_busy1_off", int'(busy1), 0);
    chk("t1_busy2_off", int'(busy2), 0);
    chk("t1_rnd1_first", first_rnd1, 2);
    chk("t1_rnd1_last", last_rnd1, 6);
    chk("t1_rnd1_cnt", n_rnd1, 5);
    chk("t1_dv1_first", first_dv1, 8);
    chk("t1_dv2_first", first_dv2, 15);
    chk("t1_rnd2_cnt", n_rnd2, 10);

    // NBLOCKS=2, block 1 delayed 3 cycles, spurious start in ROUND, digest stalled 4 cycles
    do_rst(); nxt(); msg_valid = 1'b1; go(); start = 1'b0;
    for (int c = 2; c <= 22; c++) begin
      nxt();
      msg_valid = (c >= 11 && c <= 11);
      start     = (c == 5);
      dig_ready = (c == 22);
      #3;
      if (c == 8) begin
        chk("t2_bf_blk1", int'(bf2), 0);
        chk("t2_rdy_blk1", int'(rdy2), 1);
      end
      if (c == 10) chk("t2_stall_ld", int'(ld2), 0);
      if (c == 21) chk("t2_dv_held", int'(dv2), 1);
    end
    nxt(); #3;
    chk("t2_busy_off", int'(busy2), 0);
    chk("t2_rnd_cnt", n_rnd2, 10);
    chk("t2_ld_cnt", n_ld2, 2);
    chk("t2_bf_cnt", n_bf2, 7);
    chk("t2_dv_first", first_dv2, 18);
    chk("t2_dv_cnt", n_dv2, 5);

    // spurious rnd_co / dig_ready / msg_valid in IDLE, rnd_co in LOAD
    do_rst(); nxt(); cyc = 0; clr();
    co_force = 1'b1; dig_ready = 1'b1; msg_valid = 1'b1;
    repeat (3) nxt();
    #3;
    chk("t3_idle_busy", int'(busy2), 0);
    start = 1'b1; msg_valid = 1'b0;
    nxt(); start = 1'b0;
    repeat (2) nxt();
    #3;
    chk("t3_load_hold", int'(rdy2), 1);
    chk("t3_no_rnd", n_rnd2, 0);
    co_force = 1'b0; msg_valid = 1'b1;
    nxt(); #3;
    chk("t3_round_rnd", int'(re2), 1);

    // reset mid-ROUND of block 1 acts without a clock edge
    do_rst(); nxt(); msg_valid = 1'b1; dig_ready = 1'b0; go(); start = 1'b0;
    while (cyc < 10) nxt();
    #3;
    chk("t4_pre_busy", int'(busy2), 1);
    chk("t4_pre_bf", int'(bf2), 0);
    rst = 1'b1;
    #1;
    chk("t4_async_busy", int'(busy2), 0);
    chk("t4_async_init", int'(ci2), 1);
    @(posedge clk); #1 rst = 1'b0;
    go(); start = 1'b0;
    #3;
    chk("t4_new_bf", int'(bf2), 1);
    chk("t4_new_ld", int'(ld2), 1);

    // back-to-back: start held through digest acceptance
    do_rst(); nxt(); msg_valid = 1'b1; dig_ready = 1'b1; go();
    while (cyc < 17) begin
      #3;
      if (cyc == 15) chk("t5_dv", int'(dv2), 1);
      if (cyc == 16) chk("t5_idle", int'(busy2), 0);
      nxt();
    end
    #3;
    chk("t5_restart_ld", int'(ld2), 1);
    chk("t5_restart_bf", int'(bf2), 1);
    start = 1'b0;

`ifdef HASH_ROUND_CTRL_ABORT_EN
    // abort in cycle 4 returns to IDLE at cycle 5, then a clean hash follows
    do_rst(); nxt(); msg_valid = 1'b1; dig_ready = 1'b0; go(); start = 1'b0;
    while (cyc < 4) nxt();
    abort = 1'b1;
    nxt(); abort = 1'b0;
    #3;
    chk("t6_abort_idle", int'(busy2), 0);
    chk("t6_abort_init", int'(ci2), 1);
    while (cyc < 25) nxt();
    chk("t6_no_dv", n_dv2, 0);
    go(); start = 1'b0;
    while (cyc < 16) nxt();
    chk("t6_after_dv", first_dv2, 15);
    chk("t6_after_bf", n_bf2, 7);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
